// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path: byte type and arbiter FSM states.
package uart_pkg;

   typedef logic [7:0] uart_byte_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT_BUSY,
      ST_WAIT_DONE
   } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set bit of req scanning upward
// from last+1, wrapping. Reusable by any arbiter that keeps its own 'last'.
module rr_picker #(
   parameter int p_num_req = 4
) (
   input  logic [p_num_req-1:0]         req,
   input  logic [$clog2(p_num_req)-1:0] last,
   output logic [$clog2(p_num_req)-1:0] idx,
   output logic                         found
);

   localparam int c_idx_w = $clog2(p_num_req);

   always_comb begin
      int k;
      // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
      idx   = '0;
      found = 1'b0;
      k     = 0;
      // Scan from farthest to nearest so the candidate closest to last+1 is written last and wins.
      for (int i = p_num_req; i >= 1; i--) begin
         k = int'(last) + i;
         if (k >= p_num_req) k = k - p_num_req;
         if (req[k[c_idx_w-1:0]]) begin
            idx   = k[c_idx_w-1:0];
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between byte requesters, with
// locked bursts, start-timeout detection and busy tracking.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int p_num_req       = 4,
   parameter int p_max_burst     = 16,
   parameter int p_start_timeout = 8
) (
   input  logic                         clk_i,
   input  logic                         rst_n_i,
   input  logic [p_num_req-1:0]         req_valid_i,
   input  logic [p_num_req-1:0]         req_lock_i,
   input  logic [p_num_req*8-1:0]       req_data_i,
   output logic [p_num_req-1:0]         req_ready_o,
   output logic                         tx_start_o,
   output logic [7:0]                   tx_data_o,
   input  logic                         tx_busy_i,
   output logic [$clog2(p_num_req)-1:0] grant_id_o,
   output logic                         active_o,
   output logic                         start_err_o
);

   localparam int c_idx_w   = $clog2(p_num_req);
   localparam int c_burst_w = $clog2(p_max_burst + 1);
   localparam int c_tmo_w   = (p_start_timeout > 1) ? $clog2(p_start_timeout) : 1;

   localparam logic [c_idx_w-1:0]   c_last_rst = c_idx_w'(p_num_req - 1);
   localparam logic [c_burst_w:0]   c_burst_lim = (c_burst_w + 1)'(p_max_burst);
   localparam logic [c_burst_w-1:0] c_burst_sat = '1;
   localparam logic [c_tmo_w-1:0]   c_tmo_last = c_tmo_w'(p_start_timeout - 1);

   arb_state_e           state_q, state_d;
   logic [c_idx_w-1:0]   last_q, last_d;
   logic [c_idx_w-1:0]   grant_q, grant_d;
   logic                 hold_q, hold_d;
   logic [c_burst_w-1:0] burst_q, burst_d;
   logic [c_tmo_w-1:0]   tmo_q, tmo_d;
   uart_byte_t           data_q, data_d;

   uart_byte_t           req_byte [p_num_req];
   logic [c_idx_w-1:0]   pick_idx;
   logic                 pick_found;
   logic                 owner_valid;
   logic [c_idx_w-1:0]   win_idx;

   for (genvar n = 0; n < p_num_req; n++) begin : g_bytes
      assign req_byte[n] = req_data_i[n*8 +: 8];
   end

   rr_picker #(
      .p_num_req (p_num_req)
   ) u_picker (
      .req   (req_valid_i),
      .last  (last_q),
      .idx   (pick_idx),
      .found (pick_found)
   );

   // A held owner keeps the grant only while it still has a byte to offer.
   assign owner_valid = req_valid_i[last_q];
   assign win_idx     = (hold_q && owner_valid) ? last_q : pick_idx;

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      grant_d     = grant_q;
      hold_d      = hold_q;
      burst_d     = burst_q;
      tmo_d       = tmo_q;
      data_d      = data_q;
      req_ready_o = '0;
      tx_start_o  = 1'b0;
      start_err_o = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (hold_q && !owner_valid) begin
               hold_d  = 1'b0;
               burst_d = '0;
            end
            // Ready is combinational from IDLE, so it is gated by reset to stay low while held.
            if (rst_n_i && !tx_busy_i && pick_found) begin
               req_ready_o[win_idx] = 1'b1;
               data_d               = req_byte[win_idx];
               last_d               = win_idx;
               grant_d              = win_idx;
               state_d              = ST_LAUNCH;
            end
         end

         ST_LAUNCH: begin
            tx_start_o = 1'b1;
            tmo_d      = '0;
            state_d    = ST_WAIT_BUSY;
         end

         ST_WAIT_BUSY: begin
            if (tx_busy_i) begin
               state_d = ST_WAIT_DONE;
            end else if (tmo_q == c_tmo_last) begin
               start_err_o = 1'b1;
               hold_d      = 1'b0;
               burst_d     = '0;
               state_d     = ST_IDLE;
            end else begin
               tmo_d = tmo_q + c_tmo_w'(1);
            end
         end

         ST_WAIT_DONE: begin
            if (!tx_busy_i) begin
               state_d = ST_IDLE;
               if (req_lock_i[last_q] && (({1'b0, burst_q} + (c_burst_w + 1)'(1)) < c_burst_lim)) begin
                  hold_d  = 1'b1;
                  burst_d = (burst_q == c_burst_sat) ? burst_q : burst_q + c_burst_w'(1);
               end else begin
                  hold_d  = 1'b0;
                  burst_d = '0;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         last_q  <= c_last_rst;
         grant_q <= '0;
         hold_q  <= 1'b0;
         burst_q <= '0;
         tmo_q   <= '0;
         data_q  <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         hold_q  <= hold_d;
         burst_q <= burst_d;
         tmo_q   <= tmo_d;
         data_q  <= data_d;
      end
   end

   assign tx_data_o  = data_q;
   assign grant_id_o = grant_q;
   assign active_o   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter against a per-frame
// transaction model with a stub transmitter owned by the bench.
module tb_uart_tx_arbiter;

   localparam int N    = 4;
   localparam int MAXB = 16;
   localparam int TMO  = 8;

   logic           clk_i       = 1'b0;
   logic           rst_n_i     = 1'b0;
   logic [N-1:0]   req_valid_i = '0;
   logic [N-1:0]   req_lock_i  = '0;
   logic [N*8-1:0] req_data_i  = '0;
   logic [N-1:0]   req_ready_o;
   logic           tx_start_o;
   logic [7:0]     tx_data_o;
   logic           tx_busy_i   = 1'b0;
   logic [1:0]     grant_id_o;
   logic           active_o;
   logic           start_err_o;

   uart_tx_arbiter #(
      .p_num_req       (N),
      .p_max_burst     (MAXB),
      .p_start_timeout (TMO)
   ) dut (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .req_valid_i (req_valid_i),
      .req_lock_i  (req_lock_i),
      .req_data_i  (req_data_i),
      .req_ready_o (req_ready_o),
      .tx_start_o  (tx_start_o),
      .tx_data_o   (tx_data_o),
      .tx_busy_i   (tx_busy_i),
      .grant_id_o  (grant_id_o),
      .active_o    (active_o),
      .start_err_o (start_err_o)
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   // requester byte queues and lock levels
   logic [7:0] q [N][$];
   logic [N-1:0] lock_cfg = '0;
   bit rand_mode = 0;

   // stub transmitter: busy over [busy_on, busy_off)
   bit foreign_busy = 0;
   int busy_on = -1, busy_off = -1;
   bit st_never = 0;
   int st_len = 0, st_dly = 0;

   // reference model
   int m_last, m_grant, m_burst;
   bit m_hold, m_in_frame, m_frame_never;
   logic [7:0] m_data;
   int m_start_cyc, m_err_cyc;

   // DUT-observed launches
   logic [7:0] obs_data [$];
   int obs_grant [$];
   int start_seen_cyc = -1;
   int err_delta = -1;
   int ready_cnt = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic bit pending();
      bit p;
      p = m_in_frame;
      for (int n = 0; n < N; n++) if (q[n].size() != 0) p = 1;
      return p;
   endfunction

   task automatic model_reset();
      m_last = N - 1; m_grant = 0; m_burst = 0;
      m_hold = 0; m_in_frame = 0; m_frame_never = 0;
      m_data = 8'h00; m_start_cyc = -1; m_err_cyc = -1;
   endtask

   task automatic apply_reset();
      rst_n_i = 1'b0;
      for (int n = 0; n < N; n++) q[n].delete();
      foreign_busy = 0; busy_on = -1; busy_off = -1;
      st_never = 0; st_len = 0; st_dly = 0; lock_cfg = '0;
      model_reset();
      req_valid_i = '1; req_lock_i = '1; req_data_i = 32'hA5C3_5A3C; tx_busy_i = 1'b0;
      #1;
      check("rst_ready", req_ready_o, 0);
      check("rst_start", tx_start_o, 0);
      check("rst_data", tx_data_o, 0);
      check("rst_grant", grant_id_o, 0);
      check("rst_active", active_o, 0);
      check("rst_err", start_err_o, 0);
      req_valid_i = '0; req_lock_i = '0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      @(posedge clk_i);
      #1;
   endtask

   // One clock cycle: drive, compare at negedge, advance the model.
   task automatic step();
      logic [N-1:0] v, exp_ready;
      int w, dly, len;
      bit never;
      if (rand_mode) begin
         for (int n = 0; n < N; n++)
            if (q[n].size() == 0 && $urandom_range(0, 3) == 0)
               repeat ($urandom_range(1, 5)) q[n].push_back(8'($urandom()));
         lock_cfg = N'($urandom_range(0, 15));
      end
      for (int n = 0; n < N; n++) begin
         v[n] = (q[n].size() != 0);
         req_data_i[n*8 +: 8] = v[n] ? q[n][0] : 8'h00;
      end
      req_valid_i = v;
      req_lock_i  = lock_cfg;
      tx_busy_i   = foreign_busy || (cyc >= busy_on && cyc < busy_off);
      @(negedge clk_i);

      exp_ready = '0;
      w = -1;
      if (!m_in_frame) begin
         if (m_hold && !v[m_last]) begin m_hold = 0; m_burst = 0; end
         if (!tx_busy_i && v != 0) begin
            if (m_hold) w = m_last;
            else for (int i = 1; i <= N; i++) if (w < 0 && v[(m_last + i) % N]) w = (m_last + i) % N;
            exp_ready[w] = 1'b1;
         end
      end
      check("ready", req_ready_o, exp_ready);
      check("start", tx_start_o, cyc == m_start_cyc);
      check("err", start_err_o, cyc == m_err_cyc);
      check("active", active_o, m_in_frame);
      check("data", tx_data_o, m_data);
      check("grant", grant_id_o, m_grant);
      if (tx_start_o) begin
         obs_data.push_back(tx_data_o);
         obs_grant.push_back(int'(grant_id_o));
         start_seen_cyc = cyc;
      end
      if (start_err_o) err_delta = cyc - start_seen_cyc;
      if (req_ready_o != 0) ready_cnt++;

      if (m_in_frame) begin
         if (m_frame_never && cyc == m_err_cyc) begin
            m_hold = 0; m_burst = 0; m_in_frame = 0;
         end else if (!m_frame_never && cyc == busy_off) begin
            if (lock_cfg[m_last] && m_burst + 1 < MAXB) begin m_hold = 1; m_burst++; end
            else begin m_hold = 0; m_burst = 0; end
            m_in_frame = 0;
         end
      end else if (w >= 0) begin
         m_data = q[w].pop_front();
         m_last = w; m_grant = w; m_in_frame = 1;
         m_start_cyc = cyc + 1;
         never = st_never || (rand_mode && $urandom_range(0, 9) == 0);
         st_never = 0;
         m_frame_never = never;
         if (never) begin
            m_err_cyc = cyc + 1 + TMO; busy_on = -1; busy_off = -1;
         end else begin
            dly = (st_dly != 0) ? st_dly : $urandom_range(1, TMO);
            len = (st_len != 0) ? st_len : $urandom_range(1, 6);
            busy_on = cyc + 1 + dly; busy_off = busy_on + len;
         end
      end
      @(posedge clk_i);
      #1;
      cyc++;
   endtask

   task automatic drain(input int budget);
      int left;
      left = budget;
      while (pending() && left > 0) begin step(); left--; end
      check("drain", pending(), 0);
      repeat (2) step();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rr_exp [5];
      int lead, left;
      rr_exp = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h41};

      apply_reset();

      // single requester, long frame
      obs_data.delete(); obs_grant.delete();
      q[0].push_back(8'h48); st_dly = 1; st_len = 20;
      drain(200);
      st_dly = 0; st_len = 0;
      check("single_count", obs_data.size(), 1);
      if (obs_data.size() > 0) check("single_byte", obs_data[0], 8'h48);

      // round robin from reset
      apply_reset();
      obs_data.delete(); obs_grant.delete();
      q[0].push_back(8'h41); q[0].push_back(8'h41);
      q[1].push_back(8'h42); q[2].push_back(8'h43); q[3].push_back(8'h44);
      drain(400);
      check("rr_count", obs_data.size(), 5);
      for (int i = 0; i < 5 && i < obs_data.size(); i++) begin
         check("rr_byte", obs_data[i], rr_exp[i]);
         check("rr_grant", obs_grant[i], i % N);
      end

      // locked burst: requester 2 locked with 20 bytes, requester 0 waiting
      obs_data.delete(); obs_grant.delete();
      lock_cfg = 4'b0100;
      for (int i = 0; i < 20; i++) q[2].push_back(8'(8'h80 + i));
      q[0].push_back(8'h30);
      drain(2000);
      lead = 0;
      while (lead < obs_grant.size() && obs_grant[lead] == 2) lead++;
      check("lock_run", lead, MAXB);
      check("lock_break", obs_grant.size() > 16 ? obs_grant[16] : 99, 0);
      check("lock_resume", obs_grant.size() > 17 ? obs_grant[17] : 99, 2);
      check("lock_total", obs_grant.size(), 21);
      lock_cfg = '0;

      // start timeout, then the next requester is served
      obs_data.delete(); obs_grant.delete();
      err_delta = -1;
      st_never = 1;
      q[3].push_back(8'hEE); q[1].push_back(8'h11);
      drain(400);
      check("tmo_delta", err_delta, TMO);
      check("tmo_count", obs_grant.size(), 2);
      if (obs_grant.size() == 2) begin
         check("tmo_first", obs_grant[0], 3);
         check("tmo_next", obs_grant[1], 1);
      end

      // foreign busy in IDLE blocks acceptance
      obs_data.delete(); obs_grant.delete();
      foreign_busy = 1; ready_cnt = 0;
      q[0].push_back(8'h5A); q[2].push_back(8'hA5);
      repeat (12) step();
      check("busy_block", ready_cnt, 0);
      foreign_busy = 0;
      drain(400);
      check("busy_release", obs_grant.size(), 2);

      // reset during WAIT_DONE
      repeat (3) q[1].push_back(8'h77);
      st_dly = 1; st_len = 30;
      left = 60;
      while (!(m_in_frame && busy_on >= 0 && cyc > busy_on + 1 && cyc < busy_off - 1) && left > 0) begin
         step(); left--;
      end
      check("midrst_reach", left > 0, 1);
      apply_reset();
      obs_data.delete(); obs_grant.delete();
      q[2].push_back(8'h22); q[0].push_back(8'h00);
      drain(400);
      check("midrst_first", obs_grant.size() > 0 ? obs_grant[0] : 99, 0);

      // randomized traffic with random locks and occasional start timeouts
      rand_mode = 1;
      repeat (2000) step();
      rand_mode = 0;
      drain(3000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `uart_tx` transmitter between `p_num_req` byte requesters. It accepts one byte at a time over per-requester valid/ready handshakes and launches it on the transmitter with a one-cycle start pulse. It then tracks the transmitter's `busy` until the frame completes. It sits between on-chip byte sources (console, debug, status reporter) and the single TX pin, and supports short locked bursts so a multi-byte message is not interleaved.

## Interface
Parameters:
- `p_num_req`, 4: number of requesters, 2..8.
- `p_max_burst`, 16: maximum consecutive bytes granted to one locked requester before forced rotation.
- `p_start_timeout`, 8: cycles to wait for `tx_busy_i` after a start pulse before declaring an error.

Ports:
- `clk_i`, input, 1: single clock.
- `rst_n_i`, input, 1: asynchronous, active-low reset.
- `req_valid_i`, input, `p_num_req`: requester n has a byte.
- `req_lock_i`, input, `p_num_req`: requester n asks to keep the grant after its current byte.
- `req_data_i`, input, `p_num_req*8`: byte of requester n is at bits [8n+7:8n].
- `req_ready_o`, output, `p_num_req`: byte of requester n accepted this cycle. One-hot or zero.
- `tx_start_o`, output, 1: one-cycle launch pulse to the transmitter.
- `tx_data_o`, output, 8: byte presented to the transmitter. Held stable from the start pulse until done.
- `tx_busy_i`, input, 1: transmitter frame in progress.
- `grant_id_o`, output, `$clog2(p_num_req)`: current or last owner.
- `active_o`, output, 1: the arbiter is not in IDLE.
- `start_err_o`, output, 1: one-cycle pulse when the transmitter did not go busy within `p_start_timeout` cycles.

## Operation
- States are IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
- **IDLE:**
  - If `tx_busy_i`=0 and any `req_valid_i` is set, the arbiter selects a winner w.
    - When the burst is held (`hold`=1), w is the previous owner, provided it is still valid.
    - Otherwise w is the first valid requester scanning upward from `last+1`, wrapping modulo `p_num_req`.
  - `req_ready_o[w]`=1 combinationally in the same cycle.
  - The arbiter latches `req_data_i[w]` into `tx_data_o`, sets `last`=w, and moves to LAUNCH.
  - If `tx_busy_i`=1, no `req_ready_o` is raised.
- **LAUNCH:** `tx_start_o`=1 for exactly one cycle, then the FSM moves to WAIT_BUSY with the timeout counter cleared.
- **WAIT_BUSY:**
  - `tx_busy_i`=1 → WAIT_DONE.
  - If the counter reaches `p_start_timeout-1` with busy still 0, the FSM pulses `start_err_o` and returns to IDLE. The byte is dropped, `hold` is cleared and the burst count is cleared.
- **WAIT_DONE:** `tx_busy_i`=0 → IDLE.
  - Set `hold`=1 if `req_lock_i[last]`=1 and the burst count+1 < `p_max_burst`.
    - The burst count then increments.
  - Otherwise `hold`=0 and the burst count is cleared.
- A held owner that deasserts `req_valid_i` in IDLE forfeits the hold: normal round-robin applies, and `hold` and the burst count are cleared.
- `req_lock_i` is sampled only at the WAIT_DONE→IDLE transition.
- The burst count is `$clog2(p_max_burst+1)` bits and saturates, never wrapping.

## Timing
- **Reset values:**
  - `req_ready_o`=0, `tx_start_o`=0, `tx_data_o`=8'h00, `grant_id_o`=0, `active_o`=0, `start_err_o`=0.
  - State=IDLE, `last`=`p_num_req-1` so requester 0 wins first, `hold`=0, burst count=0.
- Reset asserted mid-frame returns to IDLE immediately. Any byte accepted but not launched is lost. No start pulse is emitted after the release of reset.
- **Latency:** acceptance in cycle T, `tx_start_o` in T+1. The earliest next acceptance is the cycle after busy falls.
- **Requester rule:** `req_data_i` must be valid whenever `req_valid_i` is high. Transfer happens on valid&ready. Requesters may not withdraw valid without a transfer. The arbiter tolerates withdrawal.
- **Simultaneous requests:** exactly one grant per frame. Under sustained full load every requester is served within `p_num_req` frames, unless a locked burst is in progress, which is bounded by `p_max_burst`.
- `tx_busy_i` already high in IDLE (a foreign or stuck frame) blocks acceptance.

## Structure
- Package `uart_pkg` holds the arbiter state enum and a shared `uart_byte_t` (logic [7:0]) typedef.
- Sub-module `rr_picker`: combinational first-set search from a rotating start index. Inputs are a request vector and `last`; outputs are an index and a found flag. It is reusable by later arbiters.
- The remainder is one FSM with timeout and burst counters, 150–250 lines in total.

## Test plan
- **Single requester:** `req_valid_i`=4'b0001, data 8'h48 (stub transmitter holds busy for 20 cycles) → `req_ready_o`=0001 one cycle, `tx_start_o` the next cycle, `tx_data_o`=8'h48 until busy falls.
- **Round-robin:** all 4 valid and unlocked, with bytes "A","B","C","D" → transmitted order "A","B","C","D","A". `grant_id_o` steps 0,1,2,3,0.
- **Locked burst:** requester 2 holds lock with 20 bytes queued while requester 0 is valid → 16 consecutive bytes from 2, then one byte from 0, then requester 2 resumes.
- **Timeout:** the stub never asserts busy → `start_err_o` pulses exactly 8 cycles after `tx_start_o`. The FSM returns to IDLE and the next requester is served.
- **Reset mid-frame:** `rst_n_i` is dropped during WAIT_DONE → all outputs are at reset values asynchronously. After release the next grant goes to requester 0.
- **Busy in IDLE:** `tx_busy_i`=1 while requesters are valid → no `req_ready_o` until busy clears.
